// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential PC generation, credit-limited memory requests,
// an in-order response FIFO and redirect flushing. `define FETCH_PERF_EN adds pop/stall counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    entry_t           fifo_q [FIFO_DEPTH];
    entry_t           fifo_d [FIFO_DEPTH];

    logic req_fire, push, pop;

    // Credit check counts in-flight requests against free FIFO slots, so a push never overflows.
    assign imem_req_valid = reset && !redirect_valid && (outst_q < MAX_C)
                            && ((outst_q + count_q) < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign instr_valid    = (count_q != '0);
    assign instruction    = fifo_q[rd_ptr_q].data;
    assign instr_pc       = fifo_q[rd_ptr_q].pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign push     = imem_resp_valid && !redirect_valid && (drop_q == '0);
    assign pop      = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_d     = fifo_q;

        case ({req_fire, imem_resp_valid})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;

        if (push) begin
            fifo_d[wr_ptr_q] = '{data: imem_resp_data, pc: resp_pc_q};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            resp_pc_d        = resp_pc_q + 32'd4;
        end else if (imem_resp_valid && drop_q != '0) begin
            drop_d = drop_q - CNT_W'(1);
        end

        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        // Everything still in flight becomes stale; a response in this very cycle is discarded too.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            resp_pc_d  = redirect_pc & ~32'h3;
            drop_d     = outst_q - CNT_W'(imem_resp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            // NOTE: the buffer is tiny and the head is visible at the ports, so storage is reset too.
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_q     <= fifo_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + (pop ? 32'd1 : 32'd0);
        stall_count_d = stall_count_q + ((instr_valid && !instr_ready) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order memory model with random latency and a
// stream-level reference (expected PC sequence restarting at each redirect).
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction, instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count;
`endif

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
`ifdef FETCH_PERF_EN
        .fetch_count     (fetch_count),
        .stall_count     (stall_count),
`endif
        .instruction     (instruction),
        .instr_pc        (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    int tests = 0, fails = 0, cyc = 0;
    int req_rdy_pct = 100, instr_rdy_pct = 100, lat_min = 1, lat_max = 1, redir_pm = 0;
    bit force_redir = 0, arm_coinc = 0, coinc_hit = 0;
    logic [31:0] force_pc, coinc_pc;
    logic [31:0] exp_req_pc, exp_pc, held_data, held_pc, last_pop_pc;
    bit prev_redir, prev_stall;
    int pops, stalls, first_hs, first_valid, release_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_req_pc  = RESET_PC;
        exp_pc      = RESET_PC;
        prev_redir  = 0;
        prev_stall  = 0;
        pops        = 0;
        stalls      = 0;
        first_hs    = -1;
        first_valid = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_valid"}, instr_valid, 0);
        check({tag, "_req_valid"}, imem_req_valid, 0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_instruction"}, instruction, 0);
        check({tag, "_instr_pc"}, instr_pc, 0);
`ifdef FETCH_PERF_EN
        check({tag, "_fetch_count"}, fetch_count, 0);
        check({tag, "_stall_count"}, stall_count, 0);
`endif
    endtask

    task automatic assert_reset_now(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        release_cyc = cyc + 1;
    endtask

    // One clock cycle: drive inputs after negedge, sample, then update the reference.
    task automatic do_cycle();
        @(negedge clk);
        cyc++;
        imem_req_ready = ($urandom_range(99) < req_rdy_pct);
        instr_ready    = ($urandom_range(99) < instr_rdy_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        redirect_valid = force_redir || ($urandom_range(999) < redir_pm);
        redirect_pc    = force_redir ? force_pc : $urandom;
        force_redir    = 0;
        #1;
        if (arm_coinc && imem_resp_valid && instr_valid) begin
            instr_ready    = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = coinc_pc;
            arm_coinc      = 0;
            coinc_hit      = 1;
            #1;
        end

        if (prev_redir) check("flush_after_redirect", instr_valid, 0);
        if (prev_stall) begin
            check("hold_valid", instr_valid, 1);
            check("hold_data", instruction, held_data);
            check("hold_pc", instr_pc, held_pc);
        end
        if (redirect_valid) check("no_req_in_redirect", imem_req_valid, 0);
        if (instr_valid && first_valid < 0) first_valid = cyc;

        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_req_pc);
            check("outstanding_limit", pend.size() < MAXO, 1);
            if (first_hs < 0) first_hs = cyc;
            pend.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
            exp_req_pc += 32'd4;
        end
        if (imem_resp_valid) void'(pend.pop_front());

        if (instr_valid && instr_ready && !redirect_valid) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instruction", instruction, mem_word(exp_pc));
            last_pop_pc = instr_pc;
            exp_pc += 32'd4;
            pops++;
        end
        if (instr_valid && !instr_ready) stalls++;

        prev_stall = instr_valid && !instr_ready && !redirect_valid;
        held_data  = instruction;
        held_pc    = instr_pc;
        if (redirect_valid) begin
            exp_pc     = redirect_pc & ~32'h3;
            exp_req_pc = redirect_pc & ~32'h3;
        end
        prev_redir = redirect_valid;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic redirect_and_check_first(input logic [31:0] target, input logic [31:0] exp_first);
        int start_pops;
        bit got;
        force_redir = 1;
        force_pc    = target;
        do_cycle();
        start_pops = pops;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            do_cycle();
            got = (pops != start_pops);
        end
        check("redirect_first_pop_seen", got, 1);
        if (got) check("redirect_first_pc", last_pop_pc, exp_first);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");

        // Streaming with 1-cycle memory and an always-ready consumer.
        release_reset();
        run(20);
        check("first_req_cycle", first_hs, release_cyc);
        check("first_valid_latency", first_valid, first_hs + 2);
        check("stream_pops", pops > 10, 1);

        // Consumer stalls for 10 cycles, then releases.
        instr_rdy_pct = 0;
        run(10);
        check("stall_req_off", imem_req_valid, 0);
        check("stall_no_inflight", pend.size(), 0);
        check("stall_valid", instr_valid, 1);
        instr_rdy_pct = 100;
        run(10);

        // Redirect with two requests outstanding, then a misaligned target.
        lat_min = 4; lat_max = 4;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            do_cycle();
            ok = (pend.size() == 2);
        end
        check("two_outstanding_reached", ok, 1);
        redirect_and_check_first(32'h0000_0100, 32'h0000_0100);
        redirect_and_check_first(32'h0000_0103, 32'h0000_0100);

        // Redirect coinciding with a response and a pop.
        lat_min = 1; lat_max = 1;
        coinc_hit = 0;
        arm_coinc = 1;
        coinc_pc  = 32'h0000_2000;
        for (int i = 0; i < 50 && !coinc_hit; i++) do_cycle();
        check("coincident_redirect_hit", coinc_hit, 1);
        arm_coinc = 0;
        run(10);

        // PC wrap-around past 2^32.
        redirect_and_check_first(32'hFFFF_FFF8, 32'hFFFF_FFF8);
        run(10);

        // Reset mid-stream with the buffer full.
        instr_rdy_pct = 0;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            do_cycle();
            ok = instr_valid && !imem_req_valid && pend.size() == 0;
        end
        check("buffer_full_reached", ok, 1);
        assert_reset_now("mid_reset");
        instr_rdy_pct = 100;
        release_reset();
        run(10);
        check("restart_first_req", first_hs, release_cyc);

        // Counter scenario: exactly 5 pops then 3 stalled cycles.
        assert_reset_now("perf_reset");
        release_reset();
        for (int i = 0; i < 100 && pops < 5; i++) begin
            instr_rdy_pct = 100;
            do_cycle();
        end
        for (int i = 0; i < 100 && stalls < 3; i++) begin
            instr_rdy_pct = 0;
            do_cycle();
        end
        check("perf_model_pops", pops, 5);
        check("perf_model_stalls", stalls, 3);
        @(posedge clk);
        #1;
`ifdef FETCH_PERF_EN
        check("fetch_count_5", fetch_count, 5);
        check("stall_count_3", stall_count, 3);
`endif

        // Randomised traffic with occasional redirects.
        lat_min = 1; lat_max = 4;
        req_rdy_pct = 70; instr_rdy_pct = 70; redir_pm = 20;
        run(3000);
        redir_pm = 0; req_rdy_pct = 100; instr_rdy_pct = 100;
        run(20);
        check("random_pops", pops > 500, 1);
        @(posedge clk);
        #1;
`ifdef FETCH_PERF_EN
        check("fetch_count_model", fetch_count, pops);
        check("stall_count_model", stall_count, stalls);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage. Generates sequential PCs, issues requests to instruction memory and buffers returned words.
- Presents instructions in order, with their PCs, to the decode/execute stage over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight instructions and restarts fetch at a new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, output buffer entries; power of 2, ≥2.
- MAX_OUTSTANDING, 2, maximum accepted memory requests without a response; ≥1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 asserts).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_resp_valid  input  1  response valid; in order, one per accepted request, no backpressure.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  one-cycle redirect pulse.
- redirect_pc  input  32  redirect target.
- instr_valid  output  1  instruction available to decode.
- instr_ready  input  1  decode accepts instruction.
- instruction  output  32  instruction word at FIFO head.
- instr_pc  output  32  PC of instruction.

Behaviour:
- Reset values: fetch_pc=RESET_PC, resp_pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0. Outstanding count, drop count and FIFO count are all 0.
- Reset mid-operation clears all state immediately. Responses arriving while reset=0 are ignored. Memory is reset concurrently, so no stale responses arrive after release.
- Request rule: imem_req_valid=1 when all of the following hold:
  - not in reset;
  - redirect_valid=0;
  - outstanding < MAX_OUTSTANDING;
  - outstanding + fifo_count < FIFO_DEPTH. This credit rule guarantees every response has a FIFO slot.
- imem_req_addr = fetch_pc. On handshake (valid & ready), fetch_pc += 4 (wraps mod 2^32) and outstanding increments.
- The first request is asserted in the first cycle after reset is released.
- Response handling, on imem_resp_valid:
  - outstanding decrements.
  - If drop_count > 0: the word is discarded and drop_count decrements.
  - Otherwise: {imem_resp_data, resp_pc} is pushed to the FIFO and resp_pc += 4.
  - Request and response in the same cycle leave outstanding unchanged.
- Output: instr_valid = FIFO non-empty, driven from registered FIFO state.
  - A response accepted in cycle N is visible at the outputs in cycle N+1 (1-cycle latency).
  - Pop on instr_valid & instr_ready. Head values are held stable while instr_valid=1 and instr_ready=0.
  - Push and pop in the same cycle are permitted, including when the FIFO is full or empty; fifo_count is then unchanged.
- Redirect (cycle with redirect_valid=1):
  - FIFO is flushed; instr_valid=0 from the next cycle, and any pop that cycle is ignored.
  - fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}.
  - drop_count <= outstanding − (imem_resp_valid ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle; fetch resumes the next cycle at the new PC.
  - Back-to-back redirects: the last one wins. drop_count accumulates to cover all outstanding requests.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0, wrap-around.
  - fetch_count increments on each FIFO pop.
  - stall_count increments each cycle with instr_valid=1 and instr_ready=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory latency, instr_ready=1 -> requests at PC 0x0, 0x4, 0x8, …; instructions emerge in order with instr_pc matching; first instr_valid 2 cycles after the first request handshake.
- instr_ready=0 for 10 cycles -> at most FIFO_DEPTH entries held, imem_req_valid deasserts, and the head word and PC stay stable; on release, no loss or duplication.
- Redirect to 0x100 with 2 requests outstanding -> both stale responses are dropped and the next delivered instruction has instr_pc=0x100; redirect_pc=0x103 yields 0x100.
- Redirect in the same cycle as a response and a pop -> the response is discarded, the FIFO is empty next cycle, and the next request address is the target.
- reset asserted low mid-stream with 2 entries buffered -> outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
- With FETCH_PERF_EN: 5 pops and 3 stalled cycles -> fetch_count=5, stall_count=3.
